serial_add_ctrl: RTL

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_pkg.sv | 5 +
 rtl/serial_fa.sv | 11 +
 rtl/serial_add_ctrl.sv | 85 ++++++++
 3 files changed

// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared FSM state type and default operand width for the serial adder
package serial_add_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/serial_fa.sv
// serial_fa: 1-bit combinational full adder used once per shifted bit
module serial_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder, LSB first, WIDTH+1 cycle latency; SERIAL_ADD_OVF_EN adds a signed-overflow output
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             clear,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, s_sh;
  logic [CW-1:0]    cnt;
  logic             carry, s, co, last, load, step;

  serial_fa u_fa (.a(a_sh[0]), .b(b_sh[0]), .ci(carry), .s(s), .co(co));

  assign last = cnt == CW'(WIDTH - 1);
  assign load = !clear && state != SHIFT && start;
  assign step = !clear && state == SHIFT;
  assign busy = state == SHIFT;
  assign done = state == DONE;

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  end

  // next state: clear wins, SHIFT runs to the last bit, IDLE and DONE both accept start
  always_comb begin
    state_nxt = state;
    state_nxt = clear ? IDLE :
                state == SHIFT ? (last ? DONE : SHIFT) :
                start ? SHIFT : IDLE;
  end

  // operand load, per-bit shift/add and result transfer on the final bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf   <= 1'b0;
`endif
    end else if (load) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (step) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      s_sh  <= {s, s_sh[WIDTH-1:1]};
      carry <= co;
      cnt   <= last ? '0 : cnt + CW'(1);
      if (last) begin
        sum  <= {s, s_sh[WIDTH-1:1]};
        cout <= co;
`ifdef SERIAL_ADD_OVF_EN
        ovf  <= carry ^ co;
`endif
      end
    end
  end
endmodule
